// File: rtl/radio_bridge_mc_pkg.sv
// Shared types and widths for the multi-radio bridge: sequencer states,
// gain field widths and a counter-width helper.
package radio_bridge_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_TX_RAMP = 3'd2,
        ST_TX      = 3'd3,
        ST_GAP     = 3'd4
    } seq_state_t;

    localparam int TX_GAIN_W = 6;
    localparam int RF_GAIN_W = 2;
    localparam int BB_GAIN_W = 5;
    localparam int B_W       = 7;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/radio_bridge_seq.sv
// One radio's Tx/Rx sequencer: owns TxEn/RxEn, the radio_B gain bus,
// the Tx gain ramp, the turnaround gap and the sticky sequencing error.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | radio quiet, waiting for a single Tx or Rx request
// ST_RX      | RxEn high, B carries {RF, BB} gains
// ST_TX_RAMP | TxEn high, B steps up from 0 toward the Tx gain target
// ST_TX      | TxEn high, B tracks the Tx gain target, tx_ready high
// ST_GAP     | both enables low for TURNAROUND cycles before IDLE
module radio_bridge_seq
    import radio_bridge_mc_pkg::*;
#(
    parameter int RAMP_STEP  = 4,
    parameter int TURNAROUND = 8
) (
    input  logic                 converter_clock_in,
    input  logic                 reset_n,
    input  logic                 tx_req,
    input  logic                 rx_req,
    input  logic                 shdn_n,
    input  logic                 err_clr,
    input  logic [TX_GAIN_W-1:0] tx_gain,
    input  logic [RF_GAIN_W-1:0] rf_gain,
    input  logic [BB_GAIN_W-1:0] bb_gain,
    output logic                 tx_en,
    output logic                 rx_en,
    output logic                 tx_ready,
    output logic                 shdn_pin,
    output logic                 seq_error,
    output logic [B_W-1:0]       gain_b,
    output logic                 tx_active_nxt
);

    localparam int STEP_W = clog2(RAMP_STEP);
    localparam int GAP_W  = clog2(TURNAROUND);
    localparam logic [STEP_W-1:0] STEP_INIT = STEP_W'(RAMP_STEP - 1);
    localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(TURNAROUND - 1);

    seq_state_t           state_q, state_d;
    logic [TX_GAIN_W-1:0] ramp_q, ramp_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [B_W-1:0]       b_d;
    logic                 conflict;

    assign conflict = tx_req & rx_req;

    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        step_d  = step_q;
        gap_d   = gap_q;
        if (!shdn_n) begin
            state_d = ST_IDLE;
            ramp_d  = '0;
            step_d  = '0;
            gap_d   = '0;
        end else if (conflict) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_GAP;
                gap_d   = GAP_INIT;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_req) begin
                        state_d = ST_RX;
                    end else if (tx_req) begin
                        state_d = ST_TX_RAMP;
                        ramp_d  = '0;
                        step_d  = STEP_INIT;
                    end
                end
                ST_RX: begin
                    if (!rx_req) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_INIT;
                    end
                end
                ST_TX_RAMP: begin
                    if (!tx_req) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_INIT;
                    end else begin
                        // A target at or below the current ramp is taken at once.
                        if (tx_gain <= ramp_q) begin
                            ramp_d = tx_gain;
                        end else if (step_q == '0) begin
                            ramp_d = ramp_q + 1'b1;
                            step_d = STEP_INIT;
                        end else begin
                            step_d = step_q - 1'b1;
                        end
                        if (ramp_d == tx_gain) begin
                            state_d = ST_TX;
                        end
                    end
                end
                ST_TX: begin
                    if (!tx_req) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_INIT;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        b_d = '0;
        case (state_d)
            ST_RX:      b_d = {rf_gain, bb_gain};
            ST_TX_RAMP: b_d = {1'b0, ramp_d};
            ST_TX:      b_d = {1'b0, tx_gain};
            default:    b_d = '0;
        endcase
    end

    assign tx_active_nxt = (state_d == ST_TX_RAMP) || (state_d == ST_TX);

    always_ff @(posedge converter_clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ramp_q    <= '0;
            step_q    <= '0;
            gap_q     <= '0;
            tx_en     <= 1'b0;
            rx_en     <= 1'b0;
            tx_ready  <= 1'b0;
            shdn_pin  <= 1'b0;
            seq_error <= 1'b0;
            gain_b    <= '0;
        end else begin
            state_q   <= state_d;
            ramp_q    <= ramp_d;
            step_q    <= step_d;
            gap_q     <= gap_d;
            tx_en     <= tx_active_nxt;
            rx_en     <= (state_d == ST_RX);
            tx_ready  <= (state_d == ST_TX);
            shdn_pin  <= shdn_n;
            seq_error <= conflict ? 1'b1 : (err_clr ? 1'b0 : seq_error);
            gain_b    <= b_d;
        end
    end

endmodule

// File: rtl/radio_bridge_mc.sv
// Multi-radio bridge: per-radio sequencers plus registered DAC/ADC datapaths.
// Optional ADC<-DAC loopback is compiled in with RADIO_BRIDGE_MC_LOOPBACK_EN.
module radio_bridge_mc
    import radio_bridge_mc_pkg::*;
#(
    parameter int NUM_RADIOS = 4,
    parameter int DAC_WIDTH  = 16,
    parameter int ADC_WIDTH  = 14,
    parameter int RAMP_STEP  = 4,
    parameter int TURNAROUND = 8
) (
    input  logic                            converter_clock_in,
    input  logic                            reset_n,
    input  logic [NUM_RADIOS-1:0]           controller_TxEn,
    input  logic [NUM_RADIOS-1:0]           controller_RxEn,
    input  logic [NUM_RADIOS-1:0]           controller_SHDN,
    output logic [NUM_RADIOS-1:0]           controller_seq_error,
    input  logic                            controller_seq_error_clr,
    input  logic [TX_GAIN_W*NUM_RADIOS-1:0] user_Tx_gain,
    input  logic [RF_GAIN_W*NUM_RADIOS-1:0] user_RxRF_gain,
    input  logic [BB_GAIN_W*NUM_RADIOS-1:0] user_RxBB_gain,
    input  logic [DAC_WIDTH*NUM_RADIOS-1:0] user_DAC_I,
    input  logic [DAC_WIDTH*NUM_RADIOS-1:0] user_DAC_Q,
    output logic [ADC_WIDTH*NUM_RADIOS-1:0] user_ADC_I,
    output logic [ADC_WIDTH*NUM_RADIOS-1:0] user_ADC_Q,
    output logic [NUM_RADIOS-1:0]           user_tx_ready,
    output logic [DAC_WIDTH*NUM_RADIOS-1:0] radio_DAC_I,
    output logic [DAC_WIDTH*NUM_RADIOS-1:0] radio_DAC_Q,
    input  logic [ADC_WIDTH*NUM_RADIOS-1:0] radio_ADC_I,
    input  logic [ADC_WIDTH*NUM_RADIOS-1:0] radio_ADC_Q,
    output logic [NUM_RADIOS-1:0]           radio_TxEn,
    output logic [NUM_RADIOS-1:0]           radio_RxEn,
    output logic [NUM_RADIOS-1:0]           radio_SHDN,
    output logic [B_W*NUM_RADIOS-1:0]       radio_B,
    input  logic [NUM_RADIOS-1:0]           user_loopback
);

    logic [NUM_RADIOS-1:0] seq_tx_en;
    logic [NUM_RADIOS-1:0] tx_active_nxt;

    logic [DAC_WIDTH-1:0] dac_i_q   [NUM_RADIOS];
    logic [DAC_WIDTH-1:0] dac_q_q   [NUM_RADIOS];
    logic [ADC_WIDTH-1:0] adc_i_neg [NUM_RADIOS];
    logic [ADC_WIDTH-1:0] adc_q_neg [NUM_RADIOS];
    logic [ADC_WIDTH-1:0] adc_i_q   [NUM_RADIOS];
    logic [ADC_WIDTH-1:0] adc_q_q   [NUM_RADIOS];

`ifndef RADIO_BRIDGE_MC_LOOPBACK_EN
    logic unused_loopback;
    assign unused_loopback = ^user_loopback;
`endif

    for (genvar n = 0; n < NUM_RADIOS; n++) begin : g_radio
        logic [ADC_WIDTH-1:0] adc_i_src;
        logic [ADC_WIDTH-1:0] adc_q_src;

        radio_bridge_seq #(
            .RAMP_STEP  (RAMP_STEP),
            .TURNAROUND (TURNAROUND)
        ) u_seq (
            .converter_clock_in (converter_clock_in),
            .reset_n            (reset_n),
            .tx_req             (controller_TxEn[n]),
            .rx_req             (controller_RxEn[n]),
            .shdn_n             (controller_SHDN[n]),
            .err_clr            (controller_seq_error_clr),
            .tx_gain            (user_Tx_gain[n*TX_GAIN_W +: TX_GAIN_W]),
            .rf_gain            (user_RxRF_gain[n*RF_GAIN_W +: RF_GAIN_W]),
            .bb_gain            (user_RxBB_gain[n*BB_GAIN_W +: BB_GAIN_W]),
            .tx_en              (seq_tx_en[n]),
            .rx_en              (radio_RxEn[n]),
            .tx_ready           (user_tx_ready[n]),
            .shdn_pin           (radio_SHDN[n]),
            .seq_error          (controller_seq_error[n]),
            .gain_b             (radio_B[n*B_W +: B_W]),
            .tx_active_nxt      (tx_active_nxt[n])
        );

        // DAC is gated by the next state so it lines up with the TxEn pin.
        always_ff @(posedge converter_clock_in or negedge reset_n) begin
            if (!reset_n) begin
                dac_i_q[n] <= '0;
                dac_q_q[n] <= '0;
            end else begin
                dac_i_q[n] <= tx_active_nxt[n] ? user_DAC_I[n*DAC_WIDTH +: DAC_WIDTH] : '0;
                dac_q_q[n] <= tx_active_nxt[n] ? user_DAC_Q[n*DAC_WIDTH +: DAC_WIDTH] : '0;
            end
        end

        always_ff @(negedge converter_clock_in or negedge reset_n) begin
            if (!reset_n) begin
                adc_i_neg[n] <= '0;
                adc_q_neg[n] <= '0;
            end else begin
                adc_i_neg[n] <= radio_ADC_I[n*ADC_WIDTH +: ADC_WIDTH];
                adc_q_neg[n] <= radio_ADC_Q[n*ADC_WIDTH +: ADC_WIDTH];
            end
        end

`ifdef RADIO_BRIDGE_MC_LOOPBACK_EN
        logic lb_q;

        always_ff @(posedge converter_clock_in or negedge reset_n) begin
            if (!reset_n) begin
                lb_q <= 1'b0;
            end else begin
                lb_q <= user_loopback[n];
            end
        end

        assign adc_i_src     = user_loopback[n] ? dac_i_q[n][DAC_WIDTH-1 -: ADC_WIDTH] : adc_i_neg[n];
        assign adc_q_src     = user_loopback[n] ? dac_q_q[n][DAC_WIDTH-1 -: ADC_WIDTH] : adc_q_neg[n];
        assign radio_TxEn[n] = seq_tx_en[n] & ~lb_q;
`else
        assign adc_i_src     = adc_i_neg[n];
        assign adc_q_src     = adc_q_neg[n];
        assign radio_TxEn[n] = seq_tx_en[n];
`endif

        always_ff @(posedge converter_clock_in or negedge reset_n) begin
            if (!reset_n) begin
                adc_i_q[n] <= '0;
                adc_q_q[n] <= '0;
            end else begin
                adc_i_q[n] <= adc_i_src;
                adc_q_q[n] <= adc_q_src;
            end
        end

        assign radio_DAC_I[n*DAC_WIDTH +: DAC_WIDTH] = dac_i_q[n];
        assign radio_DAC_Q[n*DAC_WIDTH +: DAC_WIDTH] = dac_q_q[n];
        assign user_ADC_I[n*ADC_WIDTH +: ADC_WIDTH]  = adc_i_q[n];
        assign user_ADC_Q[n*ADC_WIDTH +: ADC_WIDTH]  = adc_q_q[n];
    end

endmodule

// File: tb/tb_radio_bridge_mc.sv
// Self-checking bench for radio_bridge_mc: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_radio_bridge_mc;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int RS = 4;
    localparam int TA = 8;

    localparam int M_IDLE = 0;
    localparam int M_RX   = 1;
    localparam int M_RAMP = 2;
    localparam int M_TX   = 3;
    localparam int M_GAP  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [NR-1:0]    c_tx = '0, c_rx = '0, c_shdn = '0, loopback = '0;
    logic             clr = 1'b0;
    logic [6*NR-1:0]  tx_gain = '0;
    logic [2*NR-1:0]  rf = '0;
    logic [5*NR-1:0]  bb = '0;
    logic [DW*NR-1:0] dac_i = '0, dac_q = '0;
    logic [AW*NR-1:0] adc_i_pin = '0, adc_q_pin = '0;

    logic [NR-1:0]    seq_err, tx_ready, tx_en, rx_en, shdn_out;
    logic [7*NR-1:0]  b_bus;
    logic [DW*NR-1:0] rdac_i, rdac_q;
    logic [AW*NR-1:0] uadc_i, uadc_q;

    int checks = 0;
    int errors = 0;

    int m_mode [NR];
    int m_level[NR];
    int m_age  [NR];
    int m_gap  [NR];

    logic [NR-1:0]    e_txen, e_rxen, e_ready, e_err, e_shdn;
    logic [7*NR-1:0]  e_b;
    logic [DW*NR-1:0] e_dac_i, e_dac_q;
    logic [AW*NR-1:0] e_adc_i, e_adc_q;

    always #5 clk = ~clk;

    radio_bridge_mc #(
        .NUM_RADIOS (NR), .DAC_WIDTH (DW), .ADC_WIDTH (AW),
        .RAMP_STEP  (RS), .TURNAROUND (TA)
    ) dut (
        .converter_clock_in       (clk),
        .reset_n                  (rst_n),
        .controller_TxEn          (c_tx),
        .controller_RxEn          (c_rx),
        .controller_SHDN          (c_shdn),
        .controller_seq_error     (seq_err),
        .controller_seq_error_clr (clr),
        .user_Tx_gain             (tx_gain),
        .user_RxRF_gain           (rf),
        .user_RxBB_gain           (bb),
        .user_DAC_I               (dac_i),
        .user_DAC_Q               (dac_q),
        .user_ADC_I               (uadc_i),
        .user_ADC_Q               (uadc_q),
        .user_tx_ready            (tx_ready),
        .radio_DAC_I              (rdac_i),
        .radio_DAC_Q              (rdac_q),
        .radio_ADC_I              (adc_i_pin),
        .radio_ADC_Q              (adc_q_pin),
        .radio_TxEn               (tx_en),
        .radio_RxEn               (rx_en),
        .radio_SHDN               (shdn_out),
        .radio_B                  (b_bus),
        .user_loopback            (loopback)
    );

    task automatic model_reset();
        for (int n = 0; n < NR; n++) begin
            m_mode[n] = M_IDLE; m_level[n] = 0; m_age[n] = 0; m_gap[n] = 0;
        end
        e_txen = '0; e_rxen = '0; e_ready = '0; e_err = '0; e_shdn = '0;
        e_b = '0; e_dac_i = '0; e_dac_q = '0; e_adc_i = '0; e_adc_q = '0;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        for (int n = 0; n < NR; n++) begin
            bit t, r;
            int target;
            t = c_tx[n];
            r = c_rx[n];
            target = int'(tx_gain[6*n +: 6]);
            if (t && r) e_err[n] = 1'b1;
            else if (clr) e_err[n] = 1'b0;
            e_shdn[n] = c_shdn[n];
            if (!c_shdn[n]) begin
                m_mode[n] = M_IDLE; m_level[n] = 0; m_age[n] = 0; m_gap[n] = 0;
            end else if (t && r) begin
                if (m_mode[n] != M_IDLE) begin
                    m_mode[n] = M_GAP; m_gap[n] = TA;
                end
            end else begin
                case (m_mode[n])
                    M_IDLE: begin
                        if (r) m_mode[n] = M_RX;
                        else if (t) begin
                            m_mode[n] = M_RAMP; m_level[n] = 0; m_age[n] = 0;
                        end
                    end
                    M_RX: if (!r) begin m_mode[n] = M_GAP; m_gap[n] = TA; end
                    M_RAMP: begin
                        if (!t) begin
                            m_mode[n] = M_GAP; m_gap[n] = TA;
                        end else if (target <= m_level[n]) begin
                            m_level[n] = target; m_mode[n] = M_TX;
                        end else begin
                            m_age[n]++;
                            if (m_age[n] == RS) begin m_level[n]++; m_age[n] = 0; end
                            if (m_level[n] == target) m_mode[n] = M_TX;
                        end
                    end
                    M_TX: if (!t) begin m_mode[n] = M_GAP; m_gap[n] = TA; end
                    default: begin
                        m_gap[n]--;
                        if (m_gap[n] == 0) m_mode[n] = M_IDLE;
                    end
                endcase
            end
            e_txen[n]  = (m_mode[n] == M_RAMP) || (m_mode[n] == M_TX);
            e_rxen[n]  = (m_mode[n] == M_RX);
            e_ready[n] = (m_mode[n] == M_TX);
            case (m_mode[n])
                M_RX:    e_b[7*n +: 7] = {rf[2*n +: 2], bb[5*n +: 5]};
                M_RAMP:  e_b[7*n +: 7] = 7'(m_level[n]);
                M_TX:    e_b[7*n +: 7] = 7'(target);
                default: e_b[7*n +: 7] = '0;
            endcase
            e_dac_i[DW*n +: DW] = e_txen[n] ? dac_i[DW*n +: DW] : '0;
            e_dac_q[DW*n +: DW] = e_txen[n] ? dac_q[DW*n +: DW] : '0;
        end
        e_adc_i = adc_i_pin;
        e_adc_q = adc_q_pin;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({seq_err, tx_ready, tx_en, rx_en, shdn_out, b_bus} !== '0) begin
            errors++; $display("FAIL reset_ctrl got=%h exp=0", {seq_err, tx_ready, tx_en, rx_en, shdn_out, b_bus});
        end
        checks++;
        if ({rdac_i, rdac_q, uadc_i, uadc_q} !== '0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {rdac_i, rdac_q, uadc_i, uadc_q});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        c_shdn = '1;
        step();
        checks++;
        if (shdn_out !== 4'hF) begin
            errors++; $display("FAIL shdn_follow got=%h exp=f", shdn_out);
        end
    endtask

    task automatic test_rx();
        rf[1:0] = 2'd2;
        bb[4:0] = 5'd17;
        c_rx[0] = 1'b1;
        checks++;
        if (rx_en[0] !== 1'b0) begin
            errors++; $display("FAIL rx_early got=%b exp=0", rx_en[0]);
        end
        step();
        checks++;
        if (rx_en[0] !== 1'b1 || tx_en[0] !== 1'b0 || b_bus[6:0] !== 7'b10_10001) begin
            errors++; $display("FAIL rx_enter rx=%b tx=%b b=%b exp rx=1 tx=0 b=1010001", rx_en[0], tx_en[0], b_bus[6:0]);
        end
        bb[4:0] = 5'd3;
        step();
        checks++;
        if (b_bus[6:0] !== 7'b10_00011) begin
            errors++; $display("FAIL rx_track got=%b exp=1000011", b_bus[6:0]);
        end
        c_rx[0] = 1'b0;
        repeat (TA + 2) step();
    endtask

    task automatic test_tx_ramp();
        tx_gain[5:0] = 6'd3;
        c_tx[0] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            int exp_b;
            step();
            exp_b = (k / RS > 3) ? 3 : k / RS;
            checks++;
            if (tx_en[0] !== 1'b1 || b_bus[6:0] !== 7'(exp_b) || tx_ready[0] !== (k >= 12)) begin
                errors++; $display("FAIL tx_ramp k=%0d tx=%b b=%0d rdy=%b exp tx=1 b=%0d rdy=%b",
                                   k, tx_en[0], b_bus[6:0], tx_ready[0], exp_b, k >= 12);
            end
        end
    endtask

    task automatic test_turnaround();
        c_tx[0] = 1'b0;
        c_rx[0] = 1'b1;
        for (int k = 0; k < TA; k++) begin
            step();
            checks++;
            if (tx_en[0] !== 1'b0 || rx_en[0] !== 1'b0 || b_bus[6:0] !== '0) begin
                errors++; $display("FAIL gap k=%0d tx=%b rx=%b b=%h exp all 0", k, tx_en[0], rx_en[0], b_bus[6:0]);
            end
        end
        step();
        checks++;
        if (rx_en[0] !== 1'b0) begin
            errors++; $display("FAIL gap_idle rx=%b exp=0", rx_en[0]);
        end
        step();
        checks++;
        if (rx_en[0] !== 1'b1) begin
            errors++; $display("FAIL gap_rx rx=%b exp=1", rx_en[0]);
        end
        c_rx[0] = 1'b0;
        repeat (TA + 2) step();
    endtask

    task automatic test_seq_error();
        c_rx[0] = 1'b1;
        c_tx[1] = 1'b1;
        tx_gain[11:6] = 6'd10;
        repeat (3) step();
        c_tx[2] = 1'b1;
        c_rx[2] = 1'b1;
        step();
        checks++;
        if (seq_err !== 4'b0100) begin
            errors++; $display("FAIL err_set got=%b exp=0100", seq_err);
        end
        checks++;
        if (rx_en[0] !== 1'b1 || tx_en[1] !== 1'b1 || tx_en[2] !== 1'b0 || rx_en[2] !== 1'b0) begin
            errors++; $display("FAIL err_others rx0=%b tx1=%b tx2=%b rx2=%b exp 1 1 0 0", rx_en[0], tx_en[1], tx_en[2], rx_en[2]);
        end
        c_tx[2] = 1'b0;
        c_rx[2] = 1'b0;
        repeat (5) step();
        checks++;
        if (seq_err !== 4'b0100) begin
            errors++; $display("FAIL err_sticky got=%b exp=0100", seq_err);
        end
        clr = 1'b1;
        c_tx[2] = 1'b1;
        c_rx[2] = 1'b1;
        step();
        checks++;
        if (seq_err[2] !== 1'b1) begin
            errors++; $display("FAIL err_set_wins got=%b exp=1", seq_err[2]);
        end
        c_tx[2] = 1'b0;
        c_rx[2] = 1'b0;
        step();
        checks++;
        if (seq_err !== 4'b0000) begin
            errors++; $display("FAIL err_clear got=%b exp=0000", seq_err);
        end
        clr = 1'b0;
        c_rx[0] = 1'b0;
        c_tx[1] = 1'b0;
        repeat (TA + 2) step();
    endtask

    task automatic test_shdn();
        tx_gain[11:6] = 6'd20;
        dac_i[31:16]  = 16'h7FFF;
        c_tx[1] = 1'b1;
        repeat (6) step();
        checks++;
        if (tx_en[1] !== 1'b1 || b_bus[13:7] !== 7'd1 || rdac_i[31:16] !== 16'h7FFF) begin
            errors++; $display("FAIL shdn_pre tx=%b b=%0d dac=%h exp 1 1 7fff", tx_en[1], b_bus[13:7], rdac_i[31:16]);
        end
        c_shdn[1] = 1'b0;
        step();
        checks++;
        if (tx_en[1] !== 1'b0 || b_bus[13:7] !== '0 || shdn_out !== 4'b1101 || rdac_i[31:16] !== '0) begin
            errors++; $display("FAIL shdn_drop tx=%b b=%0d shdn=%b dac=%h exp 0 0 1101 0",
                               tx_en[1], b_bus[13:7], shdn_out, rdac_i[31:16]);
        end
        c_tx[1]   = 1'b0;
        c_shdn[1] = 1'b1;
        dac_i     = '0;
        repeat (2) step();
    endtask

    task automatic test_datapath();
        tx_gain[23:18] = 6'd0;
        c_tx[3] = 1'b1;
        repeat (2) step();
        checks++;
        if (tx_ready[3] !== 1'b1 || rdac_i[63:48] !== '0) begin
            errors++; $display("FAIL dp_tx_entry rdy=%b dac=%h exp 1 0", tx_ready[3], rdac_i[63:48]);
        end
        dac_i[63:48] = 16'h7FFF;
        step();
        checks++;
        if (rdac_i[63:48] !== 16'h7FFF) begin
            errors++; $display("FAIL dp_dac got=%h exp=7fff", rdac_i[63:48]);
        end
        c_tx[3] = 1'b0;
        repeat (TA + 2) step();
        checks++;
        if (rdac_i[63:48] !== '0) begin
            errors++; $display("FAIL dp_dac_idle got=%h exp=0", rdac_i[63:48]);
        end
        dac_i = '0;
        adc_i_pin[13:0]  = 14'h1ABC;
        adc_q_pin[55:42] = 14'h0F0F;
        step();
        checks++;
        if (uadc_i[13:0] !== 14'h1ABC || uadc_q[55:42] !== 14'h0F0F) begin
            errors++; $display("FAIL dp_adc i=%h q=%h exp 1abc 0f0f", uadc_i[13:0], uadc_q[55:42]);
        end
        adc_i_pin[13:0] = 14'h0555;
        @(negedge clk);
        #1;
        adc_i_pin[13:0] = 14'h2AAA;
        step();
        checks++;
        if (uadc_i[13:0] !== 14'h0555) begin
            errors++; $display("FAIL dp_adc_negedge got=%h exp=0555", uadc_i[13:0]);
        end
        step();
        checks++;
        if (uadc_i[13:0] !== 14'h2AAA) begin
            errors++; $display("FAIL dp_adc_next got=%h exp=2aaa", uadc_i[13:0]);
        end
`ifdef RADIO_BRIDGE_MC_LOOPBACK_EN
        begin
            logic [15:0] word;
            word = 16'hABCD;
            loopback[0]  = 1'b1;
            tx_gain[5:0] = 6'd0;
            c_tx[0]      = 1'b1;
            dac_i[15:0]  = word;
            repeat (2) step();
            checks++;
            if (uadc_i[13:0] !== word[15:2] || tx_en[0] !== 1'b0) begin
                errors++; $display("FAIL dp_loopback adc=%h tx=%b exp %h 0", uadc_i[13:0], tx_en[0], word[15:2]);
            end
            loopback = '0;
            c_tx[0]  = 1'b0;
            dac_i    = '0;
            repeat (TA + 2) step();
        end
`endif
    endtask

    task automatic test_async_reset();
        tx_gain[17:12] = 6'd30;
        c_tx[2] = 1'b1;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({seq_err, tx_ready, tx_en, rx_en, shdn_out, b_bus, rdac_i, uadc_i} !== '0) begin
            errors++; $display("FAIL async_reset got=%h exp=0", {seq_err, tx_ready, tx_en, rx_en, shdn_out, b_bus, rdac_i, uadc_i});
        end
        c_tx = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int n = 0; n < NR; n++) begin
                if ($urandom_range(23) == 0) c_tx[n] = ~c_tx[n];
                if ($urandom_range(15) == 0) c_rx[n] = ~c_rx[n];
                c_shdn[n] = ($urandom_range(59) != 0);
                if ($urandom_range(19) == 0) tx_gain[6*n +: 6] = 6'($urandom_range(5));
            end
            clr       = ($urandom_range(15) == 0);
            rf        = 8'($urandom);
            bb        = 20'($urandom);
            dac_i     = {$urandom, $urandom};
            dac_q     = {$urandom, $urandom};
            adc_i_pin = 56'({$urandom, $urandom});
            adc_q_pin = 56'({$urandom, $urandom});
            step();
            checks++;
            if ({tx_en, rx_en, tx_ready, seq_err, shdn_out} !== {e_txen, e_rxen, e_ready, e_err, e_shdn}) begin
                errors++; $display("FAIL rand_ctrl cyc=%0d tx=%b rx=%b rdy=%b err=%b shdn=%b exp tx=%b rx=%b rdy=%b err=%b shdn=%b",
                                   cyc, tx_en, rx_en, tx_ready, seq_err, shdn_out, e_txen, e_rxen, e_ready, e_err, e_shdn);
            end
            checks++;
            if (b_bus !== e_b) begin
                errors++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, b_bus, e_b);
            end
            checks++;
            if (rdac_i !== e_dac_i || rdac_q !== e_dac_q) begin
                errors++; $display("FAIL rand_dac cyc=%0d i=%h q=%h exp i=%h q=%h", cyc, rdac_i, rdac_q, e_dac_i, e_dac_q);
            end
            checks++;
            if (uadc_i !== e_adc_i || uadc_q !== e_adc_q) begin
                errors++; $display("FAIL rand_adc cyc=%0d i=%h q=%h exp i=%h q=%h", cyc, uadc_i, uadc_q, e_adc_i, e_adc_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rx();
        test_tx_ramp();
        test_turnaround();
        test_seq_error();
        test_shdn();
        test_datapath();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
